gen_reg_file: RTL

- General-register file that sits directly downstream of the register unit. It captures write-back words and serves two registered operand reads per cycle to the execute stage.
- Keeps a per-register pending scoreboard so the pipeline can detect operands whose producer has not yet written back.
- GR0 is hardwired to zero.

---
 rtl/gen_reg_file_pkg.sv | 9 +
 rtl/gen_reg_file_if.sv | 47 ++++
 rtl/gen_reg_file_reg_scoreboard.sv | 49 ++++
 rtl/gen_reg_file.sv | 95 +++++++++
 4 files changed

// File: rtl/gen_reg_file_pkg.sv
// rtl/gen_reg_file_pkg.sv - shared constants for the general-register file
package gen_reg_file_pkg;

    localparam int WORD_LENGTH      = 32;
    localparam int GR0_IDX          = 0;
    localparam int DEFAULT_NUM_REGS = 8;
    localparam int DEFAULT_ADDR_W   = 3;

endpackage

// File: rtl/gen_reg_file_if.sv
// rtl/gen_reg_file_if.sv - read/write-back/issue bus between pipeline and register file
//
// Signals:
//   rd_en, rd_addr_a, rd_addr_b          read request (pipeline -> file)
//   rd_data_a/b, rd_busy_a/b             registered operands (file -> pipeline)
//   wr_en, wr_addr, wr_data              write-back (pipeline -> file)
//   issue_en, issue_addr                 destination of issued instruction
//   pending                              live scoreboard vector (file -> pipeline)
// Modports: master = pipeline side, slave = register file side.
interface gen_reg_file_if
    import gen_reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W
);

    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr_a;
    logic [ADDR_W-1:0]      rd_addr_b;
    logic [WORD_LENGTH-1:0] rd_data_a;
    logic [WORD_LENGTH-1:0] rd_data_b;
    logic                   rd_busy_a;
    logic                   rd_busy_b;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WORD_LENGTH-1:0] wr_data;
    logic                   issue_en;
    logic [ADDR_W-1:0]      issue_addr;
    logic [NUM_REGS-1:0]    pending;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
        output wr_en, wr_addr, wr_data,
        output issue_en, issue_addr,
        input  pending
    );

    modport slave (
        input  rd_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b,
        input  wr_en, wr_addr, wr_data,
        input  issue_en, issue_addr,
        output pending
    );

endinterface

// File: rtl/gen_reg_file_reg_scoreboard.sv
// rtl/gen_reg_file_reg_scoreboard.sv - per-register pending scoreboard with two lookup ports
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   issue_en, issue_addr   set pending for the issued destination
//   wr_en, wr_addr         clear pending on write-back
//   lookup_a, lookup_b     busy lookup indices
//   pending                current scoreboard vector
//   busy_a, busy_b         current (pre-update) pending bit at each lookup index
module gen_reg_file_reg_scoreboard
    import gen_reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [ADDR_W-1:0]   lookup_a,
    input  logic [ADDR_W-1:0]   lookup_b,
    output logic [NUM_REGS-1:0] pending,
    output logic                busy_a,
    output logic                busy_b
);

    // Issue has priority over write-back: a new producer for the same
    // register supersedes the one retiring this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == GR0_IDX)
                    pending[i] <= 1'b0;
                else if (issue_en && issue_addr == ADDR_W'(i))
                    pending[i] <= 1'b1;
                else if (wr_en && wr_addr == ADDR_W'(i))
                    pending[i] <= 1'b0;
            end
        end
    end

    assign busy_a = pending[lookup_a];
    assign busy_b = pending[lookup_b];

endmodule

// File: rtl/gen_reg_file.sv
// rtl/gen_reg_file.sv - general-register file with pending scoreboard and two registered read ports
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   gen_reg_file_if.slave (read, write-back, issue, pending)
// Build option: REG_FILE_BYPASS_EN forwards a same-edge write to the read ports.
module gen_reg_file
    import gen_reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    gen_reg_file_if.slave  bus
);

    localparam logic [ADDR_W-1:0] GR0 = ADDR_W'(GR0_IDX);

    logic [WORD_LENGTH-1:0] regs [NUM_REGS];
    logic [WORD_LENGTH-1:0] data_a_q, data_b_q;
    logic [WORD_LENGTH-1:0] data_a_nxt, data_b_nxt;
    logic                   busy_a_q, busy_b_q;
    logic                   busy_a_nxt, busy_b_nxt;
    logic                   sb_busy_a, sb_busy_b;
    logic [NUM_REGS-1:0]    sb_pending;

    gen_reg_file_reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst),
        .issue_en   (bus.issue_en),
        .issue_addr (bus.issue_addr),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .lookup_a   (bus.rd_addr_a),
        .lookup_b   (bus.rd_addr_b),
        .pending    (sb_pending),
        .busy_a     (sb_busy_a),
        .busy_b     (sb_busy_b)
    );

    // GR0 storage is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (bus.wr_en && bus.wr_addr != GR0) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Busy comes from the pre-update scoreboard, so a same-edge issue is
    // not yet visible and a same-edge write-back has not yet cleared it.
    always_comb begin
        data_a_nxt = (bus.rd_addr_a == GR0) ? '0 : regs[bus.rd_addr_a];
        data_b_nxt = (bus.rd_addr_b == GR0) ? '0 : regs[bus.rd_addr_b];
        busy_a_nxt = sb_busy_a;
        busy_b_nxt = sb_busy_b;
`ifdef REG_FILE_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == bus.rd_addr_a && bus.rd_addr_a != GR0) begin
            data_a_nxt = bus.wr_data;
            busy_a_nxt = (bus.issue_en && bus.issue_addr == bus.rd_addr_a) ? sb_busy_a : 1'b0;
        end
        if (bus.wr_en && bus.wr_addr == bus.rd_addr_b && bus.rd_addr_b != GR0) begin
            data_b_nxt = bus.wr_data;
            busy_b_nxt = (bus.issue_en && bus.issue_addr == bus.rd_addr_b) ? sb_busy_b : 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
        end else if (bus.rd_en) begin
            data_a_q <= data_a_nxt;
            data_b_q <= data_b_nxt;
            busy_a_q <= busy_a_nxt;
            busy_b_q <= busy_b_nxt;
        end
    end

    assign bus.rd_data_a = data_a_q;
    assign bus.rd_data_b = data_b_q;
    assign bus.rd_busy_a = busy_a_q;
    assign bus.rd_busy_b = busy_b_q;
    assign bus.pending   = sb_pending;

endmodule
